// File: rtl/bus_datos_uaz8.sv
// bus_datos_uaz8 - data-side bus unit for the 8-bit UAZ microcontroller.
// Decodes the 256-byte data space into a synchronous RAM (0x00..RAM_TOP)
// and an I/O page at 0xF0..0xFF with a GPIO output register, a synchronised
// GPIO input and an optional prescaled compare timer.
// Optional feature macro: BUS_DATOS_TIMER_EN builds the timer at 0xF2..0xF6;
// without it those addresses are reserved and o_Irq_Timer is tied low.

module bus_datos_uaz8 #(
    parameter logic [7:0] RAM_TOP = 8'hEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_Addres_Data_Bus,
    input  logic [7:0] i_DataOut_Bus,
    input  logic       i_RW,
    output logic [7:0] o_Dato_Bus,
    input  logic [7:0] i_Gpio,
    output logic [7:0] o_Gpio,
    output logic       o_Irq_Timer
);

    localparam logic [7:0] ADDR_GPIO_OUT  = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN   = 8'hF1;
    localparam logic [7:0] ADDR_TMR_CTRL  = 8'hF2;
    localparam logic [7:0] ADDR_TMR_PRESC = 8'hF3;
    localparam logic [7:0] ADDR_TMR_CMP   = 8'hF4;
    localparam logic [7:0] ADDR_TMR_CNT   = 8'hF5;
    localparam logic [7:0] ADDR_TMR_STAT  = 8'hF6;

    logic [7:0] ram_mem [0:RAM_TOP];
    logic [7:0] gpio_out;
    logic [7:0] gpio_sync1;
    logic [7:0] gpio_sync2;
    logic [7:0] read_data;
    logic       io_sel;
    logic       ram_sel;

    // The I/O page always owns 0xF0..0xFF, even if RAM_TOP is set higher.
    assign io_sel  = (i_Addres_Data_Bus[7:4] == 4'hF);
    assign ram_sel = !io_sel && (i_Addres_Data_Bus <= RAM_TOP);

`ifdef BUS_DATOS_TIMER_EN
    logic       tmr_en;
    logic       tmr_auto;
    logic [7:0] tmr_presc;
    logic [7:0] tmr_cmp;
    logic [7:0] tmr_cnt;
    logic       tmr_match;
    logic [7:0] presc_cnt;
    logic       tmr_tick;
    logic       wr_ctrl;
    logic       wr_presc;
    logic       wr_cmp;
    logic       wr_cnt;
    logic       wr_stat;

    assign tmr_tick = tmr_en && (presc_cnt == tmr_presc);
    assign wr_ctrl  = i_RW && (i_Addres_Data_Bus == ADDR_TMR_CTRL);
    assign wr_presc = i_RW && (i_Addres_Data_Bus == ADDR_TMR_PRESC);
    assign wr_cmp   = i_RW && (i_Addres_Data_Bus == ADDR_TMR_CMP);
    assign wr_cnt   = i_RW && (i_Addres_Data_Bus == ADDR_TMR_CNT);
    assign wr_stat  = i_RW && (i_Addres_Data_Bus == ADDR_TMR_STAT);

    // Timer state; later assignments override earlier ones, so CPU writes beat ticks and a tick's MATCH set beats W1C.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tmr_en    <= 1'b0;
            tmr_auto  <= 1'b0;
            tmr_presc <= 8'h00;
            tmr_cmp   <= 8'h00;
            tmr_cnt   <= 8'h00;
            tmr_match <= 1'b0;
            presc_cnt <= 8'h00;
        end else begin
            if (wr_stat && i_DataOut_Bus[0]) begin
                tmr_match <= 1'b0;
            end
            if (tmr_en) begin
                if (presc_cnt == tmr_presc) begin
                    presc_cnt <= 8'h00;
                end else begin
                    presc_cnt <= presc_cnt + 8'd1;
                end
            end
            if (tmr_tick) begin
                if (tmr_cnt == tmr_cmp) begin
                    tmr_match <= 1'b1;
                    if (tmr_auto) begin
                        tmr_cnt <= 8'h00;
                    end else begin
                        tmr_en <= 1'b0;
                    end
                end else begin
                    tmr_cnt <= tmr_cnt + 8'd1;
                end
            end
            if (wr_ctrl) begin
                tmr_en   <= i_DataOut_Bus[0];
                tmr_auto <= i_DataOut_Bus[1];
                if (!i_DataOut_Bus[0]) begin
                    presc_cnt <= 8'h00;
                end
            end
            if (wr_presc) begin
                tmr_presc <= i_DataOut_Bus;
            end
            if (wr_cmp) begin
                tmr_cmp <= i_DataOut_Bus;
            end
            if (wr_cnt) begin
                tmr_cnt <= i_DataOut_Bus;
            end
        end
    end

    assign o_Irq_Timer = tmr_match;
`else
    assign o_Irq_Timer = 1'b0;
`endif

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge i_Clk) begin
        if (i_RW && ram_sel) begin
            ram_mem[i_Addres_Data_Bus] <= i_DataOut_Bus;
        end
    end

    // GPIO output register and two-stage input synchroniser.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            gpio_out   <= 8'h00;
            gpio_sync1 <= 8'h00;
            gpio_sync2 <= 8'h00;
        end else begin
            gpio_sync1 <= i_Gpio;
            gpio_sync2 <= gpio_sync1;
            if (i_RW && (i_Addres_Data_Bus == ADDR_GPIO_OUT)) begin
                gpio_out <= i_DataOut_Bus;
            end
        end
    end

    // Read mux built from pre-edge state, which gives read-before-write.
    always_comb begin
        read_data = 8'h00;
        if (io_sel) begin
            case (i_Addres_Data_Bus)
                ADDR_GPIO_OUT:  read_data = gpio_out;
                ADDR_GPIO_IN:   read_data = gpio_sync2;
`ifdef BUS_DATOS_TIMER_EN
                ADDR_TMR_CTRL:  read_data = {6'b000000, tmr_auto, tmr_en};
                ADDR_TMR_PRESC: read_data = tmr_presc;
                ADDR_TMR_CMP:   read_data = tmr_cmp;
                ADDR_TMR_CNT:   read_data = tmr_cnt;
                ADDR_TMR_STAT:  read_data = {7'b0000000, tmr_match};
`endif
                default:        read_data = 8'h00;
            endcase
        end else if (ram_sel) begin
            read_data = ram_mem[i_Addres_Data_Bus];
        end
    end

    // Registered read data returned to the CPU one cycle after the address.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Dato_Bus <= 8'h00;
        end else begin
            o_Dato_Bus <= read_data;
        end
    end

    assign o_Gpio = gpio_out;

endmodule
